// File: rtl/req_arbiter.sv
// Four-requester arbiter with fixed-priority or round-robin selection.
// A grant is held until the winner signals done, drops its request, or
// reaches the hold-time limit, which releases it and pulses timeout.
module req_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    input  logic       rr_en,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last hold-counter value before a forced release.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] hold_cnt;
    logic [1:0] last_id;

    logic [1:0] start_id;
    logic [1:0] scan_id;
    logic [1:0] win_id;
    logic       win_found;
    logic       hit_limit;
    logic       release_now;

    logic [3:0] grant_next;
    logic [1:0] grant_id_next;
    logic       busy_next;
    logic       timeout_next;
    logic [7:0] hold_cnt_next;
    logic [1:0] last_id_next;

    // Scan requests downward with wrap-around from the mode-dependent start index; first set bit wins.
    always_comb begin
        start_id  = rr_en ? (last_id - 2'd1) : 2'd3;
        scan_id   = start_id;
        win_id    = 2'd0;
        win_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scan_id = start_id - 2'(k);
            if (!win_found && req[scan_id]) begin
                win_id    = scan_id;
                win_found = 1'b1;
            end
        end
    end

    assign hit_limit   = (hold_cnt == HOLD_LAST);
    assign release_now = done || !req[grant_id] || hit_limit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: arbitrate from IDLE, return to IDLE on any release condition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != 4'b0000) state_next = GRANT;
            GRANT:   if (release_now)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, hold counter and round-robin pointer.
    always_comb begin
        grant_next    = grant;
        grant_id_next = grant_id;
        busy_next     = busy;
        timeout_next  = 1'b0;
        hold_cnt_next = hold_cnt;
        last_id_next  = last_id;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    grant_next    = 4'b0001 << win_id;
                    grant_id_next = win_id;
                    busy_next     = 1'b1;
                    hold_cnt_next = 8'd0;
                    last_id_next  = win_id;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_next    = 4'b0000;
                    grant_id_next = 2'd0;
                    busy_next     = 1'b0;
                    timeout_next  = hit_limit;
                    hold_cnt_next = 8'd0;
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end
            default: begin
                grant_next    = 4'b0000;
                grant_id_next = 2'd0;
                busy_next     = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset clears everything including the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= 4'b0000;
            grant_id <= 2'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= 8'd0;
            last_id  <= 2'd0;
        end else begin
            grant    <= grant_next;
            grant_id <= grant_id_next;
            busy     <= busy_next;
            timeout  <= timeout_next;
            hold_cnt <= hold_cnt_next;
            last_id  <= last_id_next;
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: each scenario task drives one cycle at
// a time, pushing the expected outputs to a scoreboard and the observed outputs
// after the edge, then drains both queues and compares them.
module tb_req_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       t;
    } obs_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       rr_en;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    obs_t sb[$];
    obs_t seen[$];
    int   tests;
    int   failures;

    req_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .rr_en   (rr_en),
        .grant   (grant),
        .grant_id(grant_id),
        .busy    (busy),
        .timeout (timeout)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, record the expected outputs, and capture what the DUT shows after the edge.
    task automatic step(input logic [3:0] r, input logic d, input logic rr,
                        input logic [3:0] eg, input logic [1:0] eid, input logic eb, input logic et);
        obs_t e;
        obs_t o;
        req   = r;
        done  = d;
        rr_en = rr;
        e = '{g: eg, id: eid, b: eb, t: et};
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = '{g: grant, id: grant_id, b: busy, t: timeout};
        seen.push_back(o);
    endtask

    // Put the DUT back into its reset state with quiet inputs.
    task automatic do_reset();
        req   = 4'b0000;
        done  = 1'b0;
        rr_en = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t o;
        int   k;
        req   = 4'b1111;
        done  = 1'b0;
        rr_en = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
        if ({grant, grant_id, busy, timeout} !== 8'b0000_00_0_0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got grant=%b id=%0d busy=%b timeout=%b, expected all zero",
                     grant, grant_id, busy, timeout);
        end
        rst = 1'b0;
        step(4'b1111, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        k = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            o = seen.pop_front();
            tests++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL reset step %0d: got grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
                         k, o.g, o.id, o.b, o.t, e.g, e.id, e.b, e.t);
            end
            k++;
        end
    endtask

    task automatic test_fixed_priority();
        obs_t e;
        obs_t o;
        int   k;
        do_reset();
        step(4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0101, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        k = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            o = seen.pop_front();
            tests++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL fixed step %0d: got grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
                         k, o.g, o.id, o.b, o.t, e.g, e.id, e.b, e.t);
            end
            k++;
        end
    endtask

    task automatic test_round_robin();
        obs_t e;
        obs_t o;
        int   k;
        do_reset();
        step(4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        k = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            o = seen.pop_front();
            tests++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL round_robin step %0d: got grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
                         k, o.g, o.id, o.b, o.t, e.g, e.id, e.b, e.t);
            end
            k++;
        end
    endtask

    task automatic test_timeout();
        obs_t e;
        obs_t o;
        int   k;
        do_reset();
        step(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        k = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            o = seen.pop_front();
            tests++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL timeout step %0d: got grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
                         k, o.g, o.id, o.b, o.t, e.g, e.id, e.b, e.t);
            end
            k++;
        end
    endtask

    task automatic test_drop_no_preempt();
        obs_t e;
        obs_t o;
        int   k;
        do_reset();
        step(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        k = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            o = seen.pop_front();
            tests++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL drop_no_preempt step %0d: got grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
                         k, o.g, o.id, o.b, o.t, e.g, e.id, e.b, e.t);
            end
            k++;
        end
    endtask

    task automatic test_mid_reset_and_simultaneous();
        obs_t e;
        obs_t o;
        int   k;
        do_reset();
        // Round-robin grant to 1 leaves the pointer at 1 before the reset.
        step(4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        tests++;
        if ({grant, grant_id, busy, timeout} !== 8'b0000_00_0_0) begin
            failures++;
            $display("[TB] FAIL mid_grant_reset: got grant=%b id=%0d busy=%b timeout=%b, expected all zero",
                     grant, grant_id, busy, timeout);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // A cleared pointer makes the next round-robin search start at 3.
        step(4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        // done coinciding with the last hold cycle releases once, with timeout.
        step(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        k = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            o = seen.pop_front();
            tests++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL mid_reset_simul step %0d: got grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
                         k, o.g, o.id, o.b, o.t, e.g, e.id, e.b, e.t);
            end
            k++;
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        done     = 1'b0;
        rr_en    = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_drop_no_preempt();
        test_mid_reset_and_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Safety net in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
